// File: rtl/fft_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fft_pkg
// Brief    : Shared types and sizing for the radix-2 FFT stage sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package fft_pkg;

  typedef enum logic [1:0] {
    SEQ_IDLE  = 2'd0,
    SEQ_ISSUE = 2'd1,
    SEQ_DRAIN = 2'd2,
    SEQ_DONE  = 2'd3
  } seq_state_t;

  localparam int FFT_N_LOG2 = 6;
  localparam int FFT_N      = 1 << FFT_N_LOG2;

endpackage
`default_nettype wire

// File: rtl/fft_bf_addr_gen.sv
`default_nettype none
// ============================================================================
// Module   : fft_bf_addr_gen
// Brief    : Combinational (stage, k) -> operand address pair and twiddle index.
// Revision : 1.0 - initial release
// ============================================================================
module fft_bf_addr_gen
  import fft_pkg::*;
#(
  parameter int N_LOG2 = FFT_N_LOG2
) (
  input  logic [2:0]        i_stage,
  input  logic [N_LOG2-2:0] i_k,
  output logic [N_LOG2-1:0] o_addr_a,
  output logic [N_LOG2-1:0] o_addr_b,
  output logic [N_LOG2-2:0] o_tw_idx
);

  logic [N_LOG2-1:0] w_k_ext;
  logic [N_LOG2-1:0] w_half;
  logic [N_LOG2-1:0] w_pos;
  logic [N_LOG2-1:0] w_grp;
  logic [N_LOG2-1:0] w_addr_a;

  assign w_k_ext  = {1'b0, i_k};
  assign w_half   = N_LOG2'(1) << i_stage;
  assign w_pos    = w_k_ext & (w_half - N_LOG2'(1));
  assign w_grp    = w_k_ext >> i_stage;
  assign w_addr_a = (w_grp << (i_stage + 3'd1)) | w_pos;

  assign o_addr_a = w_addr_a;
  assign o_addr_b = w_addr_a | w_half;
  // pos < 2^stage, so the shifted value always fits the narrower twiddle port
  assign o_tw_idx = w_pos[N_LOG2-2:0] << (3'(N_LOG2 - 1) - i_stage);

endmodule
`default_nettype wire

// File: rtl/fft_stage_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fft_stage_sequencer
// Brief    : Stage-by-stage butterfly request scheduler for an in-place radix-2 DIT FFT.
// Revision : 1.0 - initial release
// ============================================================================
module fft_stage_sequencer
  import fft_pkg::*;
#(
  parameter int N_LOG2 = FFT_N_LOG2
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic              start,
  input  logic              abort,
  output logic              bf_valid,
  input  logic              bf_ready,
  output logic [N_LOG2-1:0] addr_a,
  output logic [N_LOG2-1:0] addr_b,
  output logic [N_LOG2-2:0] tw_idx,
  output logic [2:0]        stage,
  input  logic              wb_valid,
  output logic              busy,
  output logic              done,
  output logic              err_wb
);

  localparam logic [2:0]        c_last_stage = 3'(N_LOG2 - 1);
  localparam logic [N_LOG2-2:0] c_last_k     = '1;
  localparam logic [N_LOG2-2:0] c_k_one      = (N_LOG2-1)'(1);
  localparam logic [N_LOG2:0]   c_out_one    = (N_LOG2+1)'(1);

  seq_state_t        r_state;
  logic [N_LOG2-2:0] r_k;
  logic [2:0]        r_stage;
  logic [N_LOG2:0]   r_out;
  logic              r_bf_valid;
  logic [N_LOG2-1:0] r_addr_a;
  logic [N_LOG2-1:0] r_addr_b;
  logic [N_LOG2-2:0] r_tw;
  logic              r_busy;
  logic              r_done;
  logic              r_err;
  logic              r_drop;

  logic              w_accept;
  logic [N_LOG2-2:0] w_k_nxt;
  logic [2:0]        w_stage_nxt;
  logic [N_LOG2-1:0] w_addr_a;
  logic [N_LOG2-1:0] w_addr_b;
  logic [N_LOG2-2:0] w_tw;

  // bf_valid is only ever high in ISSUE, so this is the acceptance strobe
  assign w_accept = r_bf_valid & bf_ready;

  // Next (stage, k) so that address outputs can be registered alongside the FSM
  always_comb begin
    w_k_nxt     = r_k;
    w_stage_nxt = r_stage;
    case (r_state)
      SEQ_IDLE: begin
        if (start) begin
          w_k_nxt     = '0;
          w_stage_nxt = '0;
        end
      end
      SEQ_ISSUE: begin
        if (w_accept) w_k_nxt = r_k + c_k_one;
      end
      SEQ_DRAIN: begin
        if (r_out == '0 && r_stage != c_last_stage) begin
          w_stage_nxt = r_stage + 3'd1;
          w_k_nxt     = '0;
        end
      end
      default: ;
    endcase
    if (abort) begin
      w_k_nxt     = '0;
      w_stage_nxt = '0;
    end
  end

  fft_bf_addr_gen #(
    .N_LOG2 (N_LOG2)
  ) u_addr_gen (
    .i_stage  (w_stage_nxt),
    .i_k      (w_k_nxt),
    .o_addr_a (w_addr_a),
    .o_addr_b (w_addr_b),
    .o_tw_idx (w_tw)
  );

  always_ff @(negedge clk or negedge rstb) begin
    if (!rstb) begin
      r_state    <= SEQ_IDLE;
      r_k        <= '0;
      r_stage    <= '0;
      r_out      <= '0;
      r_bf_valid <= 1'b0;
      r_addr_a   <= '0;
      r_addr_b   <= '0;
      r_tw       <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_drop     <= 1'b0;
    end else begin
      r_done  <= 1'b0;
      r_k     <= w_k_nxt;
      r_stage <= w_stage_nxt;
      if (abort) begin
        r_state    <= SEQ_IDLE;
        r_bf_valid <= 1'b0;
        r_busy     <= 1'b0;
        r_out      <= '0;
        r_addr_a   <= '0;
        r_addr_b   <= '0;
        r_tw       <= '0;
        // stray write-backs from the cancelled transform must not flag an error
        r_drop     <= 1'b1;
      end else begin
        if (w_accept && !wb_valid) begin
          r_out <= r_out + c_out_one;
        end else if (!w_accept && wb_valid) begin
          if (r_out != '0) r_out <= r_out - c_out_one;
          else if (!r_drop) r_err <= 1'b1;
        end

        case (r_state)
          SEQ_IDLE: begin
            if (start) begin
              r_state    <= SEQ_ISSUE;
              r_bf_valid <= 1'b1;
              r_busy     <= 1'b1;
              r_err      <= 1'b0;
              r_drop     <= 1'b0;
              r_addr_a   <= w_addr_a;
              r_addr_b   <= w_addr_b;
              r_tw       <= w_tw;
            end
          end
          SEQ_ISSUE: begin
            if (w_accept) begin
              if (r_k == c_last_k) begin
                r_state    <= SEQ_DRAIN;
                r_bf_valid <= 1'b0;
              end else begin
                r_addr_a <= w_addr_a;
                r_addr_b <= w_addr_b;
                r_tw     <= w_tw;
              end
            end
          end
          SEQ_DRAIN: begin
            // barrier: the next stage reads what this stage wrote
            if (r_out == '0) begin
              if (r_stage == c_last_stage) begin
                r_state <= SEQ_DONE;
                r_done  <= 1'b1;
                r_busy  <= 1'b0;
              end else begin
                r_state    <= SEQ_ISSUE;
                r_bf_valid <= 1'b1;
                r_addr_a   <= w_addr_a;
                r_addr_b   <= w_addr_b;
                r_tw       <= w_tw;
              end
            end
          end
          SEQ_DONE: begin
            r_state <= SEQ_IDLE;
          end
          default: begin
            r_state <= SEQ_IDLE;
          end
        endcase
      end
    end
  end

  assign bf_valid = r_bf_valid;
  assign addr_a   = r_addr_a;
  assign addr_b   = r_addr_b;
  assign tw_idx   = r_tw;
  assign stage    = r_stage;
  assign busy     = r_busy;
  assign done     = r_done;
  assign err_wb   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_fft_stage_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fft_stage_sequencer
// Brief    : Directed self-checking bench for the FFT stage sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fft_stage_sequencer;
  import fft_pkg::*;

  localparam int NL     = FFT_N_LOG2;
  localparam int HALF_N = FFT_N / 2;

  logic          clk = 1'b0;
  logic          rstb, start, abort, bf_ready, wb_valid;
  logic          bf_valid, busy, done, err_wb;
  logic [NL-1:0] addr_a, addr_b;
  logic [NL-2:0] tw_idx;
  logic [2:0]    stage;

  logic [2:0]    exp_stage = '0;
  logic [NL-2:0] exp_k     = '0;
  logic [NL-1:0] ref_a, ref_b;
  logic [NL-2:0] ref_tw;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int n_acc    = 0;
  int n_done   = 0;
  int rdy_mode = 0;
  bit inj_wb      = 1'b0;
  bit barrier_en  = 1'b0;
  bit hit_s0_last = 1'b0;
  int wb_due[$];

  logic          p_valid = 1'b0, p_ready = 1'b0;
  logic [NL-1:0] p_a = '0, p_b = '0;
  logic [NL-2:0] p_tw = '0;
  logic [2:0]    p_stage = '0;

  always #5 clk = ~clk;

  fft_stage_sequencer #(.N_LOG2(NL)) dut (
    .clk      (clk),
    .rstb     (rstb),
    .start    (start),
    .abort    (abort),
    .bf_valid (bf_valid),
    .bf_ready (bf_ready),
    .addr_a   (addr_a),
    .addr_b   (addr_b),
    .tw_idx   (tw_idx),
    .stage    (stage),
    .wb_valid (wb_valid),
    .busy     (busy),
    .done     (done),
    .err_wb   (err_wb)
  );

  fft_bf_addr_gen #(.N_LOG2(NL)) u_ref (
    .i_stage  (exp_stage),
    .i_k      (exp_k),
    .o_addr_a (ref_a),
    .o_addr_b (ref_b),
    .o_tw_idx (ref_tw)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: account for the negedge just passed, then drive the next one.
  task automatic tick();
    bit ab;
    ab = abort;
    @(posedge clk);
    cyc++;
    if (p_valid && p_ready && !ab) begin
      chk("sb_stage", 32'(p_stage), 32'(exp_stage));
      chk("sb_addr_a", 32'(p_a), 32'(ref_a));
      chk("sb_addr_b", 32'(p_b), 32'(ref_b));
      chk("sb_tw", 32'(p_tw), 32'(ref_tw));
      if (exp_stage == 3'd2 && exp_k == 5) begin
        chk("vec_s2k5_a", 32'(p_a), 32'd9);
        chk("vec_s2k5_b", 32'(p_b), 32'd13);
        chk("vec_s2k5_tw", 32'(p_tw), 32'd8);
      end
      if (exp_stage == 3'd5 && exp_k == 31) begin
        chk("vec_s5k31_a", 32'(p_a), 32'd31);
        chk("vec_s5k31_b", 32'(p_b), 32'd63);
        chk("vec_s5k31_tw", 32'(p_tw), 32'd31);
      end
      if (barrier_en && exp_stage == 3'd0 && exp_k == HALF_N - 1) begin
        wb_due.push_back(cyc + 20);
        hit_s0_last = 1'b1;
      end else begin
        wb_due.push_back(cyc);
      end
      n_acc++;
      if (exp_k == {(NL-1){1'b1}}) begin
        exp_k = '0;
        exp_stage++;
      end else begin
        exp_k++;
      end
    end
    if (p_valid && !p_ready && !ab) begin
      chk("hold_addr_a", 32'(addr_a), 32'(p_a));
      chk("hold_addr_b", 32'(addr_b), 32'(p_b));
      chk("hold_tw", 32'(tw_idx), 32'(p_tw));
      chk("hold_valid", 32'(bf_valid), 32'd1);
    end
    if (done) n_done++;
    wb_valid = inj_wb;
    if (wb_due.size() > 0 && wb_due[0] <= cyc) begin
      void'(wb_due.pop_front());
      wb_valid = 1'b1;
    end
    case (rdy_mode)
      1:       bf_ready = 1'b1;
      2:       bf_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
      default: bf_ready = 1'b0;
    endcase
    p_valid = bf_valid;
    p_ready = bf_ready;
    p_a     = addr_a;
    p_b     = addr_b;
    p_tw    = tw_idx;
    p_stage = stage;
  endtask

  task automatic begin_run(input int mode);
    rdy_mode    = mode;
    n_acc       = 0;
    n_done      = 0;
    exp_stage   = '0;
    exp_k       = '0;
    hit_s0_last = 1'b0;
    wb_due.delete();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_valid", 32'(bf_valid), 32'd1);
    chk("start_err_clr", 32'(err_wb), 32'd0);
    chk("vec_s0k0_stage", 32'(stage), 32'd0);
    chk("vec_s0k0_a", 32'(addr_a), 32'd0);
    chk("vec_s0k0_b", 32'(addr_b), 32'd1);
    chk("vec_s0k0_tw", 32'(tw_idx), 32'd0);
  endtask

  task automatic finish_run(input string tag);
    for (int i = 0; i < 2000; i++) begin
      if (n_done != 0) break;
      tick();
    end
    chk({tag, "_done_seen"}, 32'(n_done != 0), 32'd1);
    repeat (3) tick();
    chk({tag, "_done_once"}, 32'(n_done), 32'd1);
    chk({tag, "_accepts"}, 32'(n_acc), 32'(HALF_N * NL));
    chk({tag, "_busy_end"}, 32'(busy), 32'd0);
    chk({tag, "_valid_end"}, 32'(bf_valid), 32'd0);
    chk({tag, "_wb_drained"}, 32'(wb_due.size()), 32'd0);
    chk({tag, "_err_end"}, 32'(err_wb), 32'd0);
  endtask

  initial begin
    rstb = 1'b0; start = 1'b0; abort = 1'b0; bf_ready = 1'b0; wb_valid = 1'b0;
    repeat (3) tick();
    chk("rst_valid", 32'(bf_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err_wb), 32'd0);
    chk("rst_addr_a", 32'(addr_a), 32'd0);
    chk("rst_addr_b", 32'(addr_b), 32'd0);
    chk("rst_tw", 32'(tw_idx), 32'd0);
    chk("rst_stage", 32'(stage), 32'd0);
    rstb = 1'b1;
    repeat (10) tick();
    chk("idle_valid", 32'(bf_valid), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);

    // Spurious write-back while idle
    inj_wb = 1'b1;
    tick();
    inj_wb = 1'b0;
    tick();
    chk("spur_err", 32'(err_wb), 32'd1);
    repeat (3) tick();
    chk("spur_err_sticky", 32'(err_wb), 32'd1);
    chk("spur_busy", 32'(busy), 32'd0);

    // Full run with an always-ready datapath
    begin_run(1);
    finish_run("full");

    // Backpressure pattern 1,0,0,1
    begin_run(2);
    finish_run("bp");

    // Stage barrier: last stage-0 write-back held back 20 cycles
    barrier_en = 1'b1;
    begin_run(1);
    for (int i = 0; i < 200; i++) begin
      if (hit_s0_last) break;
      tick();
    end
    chk("bar_reached", 32'(hit_s0_last), 32'd1);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("bar_valid_low", 32'(bf_valid), 32'd0);
      chk("bar_stage0", 32'(stage), 32'd0);
    end
    for (int i = 0; i < 10; i++) begin
      if (bf_valid) break;
      tick();
    end
    chk("bar_resume_valid", 32'(bf_valid), 32'd1);
    chk("bar_resume_stage", 32'(stage), 32'd1);
    chk("bar_resume_a", 32'(addr_a), 32'd0);
    chk("bar_resume_b", 32'(addr_b), 32'd2);
    barrier_en = 1'b0;
    finish_run("bar");

    // Abort at stage 3, k=10 with a simultaneous start
    begin_run(1);
    for (int i = 0; i < 500; i++) begin
      if (exp_stage == 3'd3 && exp_k == 10) break;
      tick();
    end
    chk("abort_reached", 32'(exp_stage == 3'd3 && exp_k == 10), 32'd1);
    chk("abort_pre_stage", 32'(stage), 32'd3);
    abort = 1'b1;
    start = 1'b1;
    tick();
    abort = 1'b0;
    start = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_valid", 32'(bf_valid), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_stage", 32'(stage), 32'd0);
    repeat (5) tick();
    chk("abort_no_done", 32'(n_done), 32'd0);
    chk("abort_no_err", 32'(err_wb), 32'd0);
    chk("abort_idle_busy", 32'(busy), 32'd0);
    chk("abort_idle_valid", 32'(bf_valid), 32'd0);

    begin_run(1);
    finish_run("post_abort");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
